// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared definitions for the ALU arbiter slice: opcode constants,
//            arbiter state encoding, default widths and the round-robin
//            priority select helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

   localparam int unsigned DATA_W_DEF = 16;   // 6Q10 fixed point
   localparam int unsigned INST_W_DEF = 4;

   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SUB   = 4'b0001;
   localparam logic [3:0] OP_MUL   = 4'b0010;
   localparam logic [3:0] OP_MAC   = 4'b0011;
   localparam logic [3:0] OP_MAT   = 4'b1001;
   localparam logic [3:0] MAT_INST = OP_MAT;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   // First valid index at or after ptr, wrapping modulo n (n <= 4).
   // Returns ptr when nothing is valid; callers qualify with |valid.
   function automatic logic [1:0] rr_pick(input logic [3:0] valid,
                                          input logic [1:0] ptr,
                                          input int unsigned n);
      logic [1:0]  pick;
      logic        found;
      int unsigned idx;
      pick  = ptr;
      found = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
         idx = (32'(ptr) + i) % n;
         if (!found && (i < n) && valid[idx[1:0]]) begin
            pick  = idx[1:0];
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : alu_rr_picker
// Purpose  : Combinational round-robin select over N_REQ requesters.
// Ports    : i_valid [N_REQ]  request vector
//            i_ptr   [IDX_W]  highest-priority index
//            o_idx   [IDX_W]  selected requester
//            o_found          at least one request is valid
// Revision : 1.0 - initial release
// ============================================================================
module alu_rr_picker
   import alu_pkg::*;
#(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned IDX_W = 1
) (
   input  logic [N_REQ-1:0] i_valid,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_found
);

   logic [3:0] w_valid4;
   logic [1:0] w_ptr2;
   logic [1:0] w_pick;

   // Widen to the helper's fixed 4-requester form; unused lanes stay 0.
   always_comb begin
      w_valid4              = '0;
      w_valid4[N_REQ-1:0]   = i_valid;
   end

   assign w_ptr2  = 2'(i_ptr);
   assign w_pick  = rr_pick(w_valid4, w_ptr2, N_REQ);
   assign o_idx   = IDX_W'(w_pick);
   assign o_found = |i_valid;

endmodule : alu_rr_picker
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Shares one fixed-point ALU between N_REQ requesters. A granted
//            requester owns the ALU for a whole transaction (one beat, or
//            MAT_BEATS beats for a matrix op) and receives its results with
//            a last flag. A watchdog frees the ALU if a result never comes.
// Ports    : i_clk, i_rst_n (async, active-low)
//            i_req_valid/o_req_ready, i_req_inst/data_a/data_b  requesters
//            o_rsp_valid (one-hot), o_rsp_last, o_rsp_data      responses
//            o_err  watchdog pulse;  o_grant  current/last owner
//            o_alu_*  / i_alu_*                                 ALU side
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int unsigned N_REQ     = 2,
   parameter int unsigned INST_W    = INST_W_DEF,
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned MAT_BEATS = 8,
   parameter logic [INST_W-1:0] MAT_INST = INST_W'(alu_pkg::OP_MAT),
   parameter int unsigned TIMEOUT   = 64
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic [N_REQ-1:0]          i_req_valid,
   output logic [N_REQ-1:0]          o_req_ready,
   input  logic [N_REQ*INST_W-1:0]   i_req_inst,
   input  logic [N_REQ*DATA_W-1:0]   i_req_data_a,
   input  logic [N_REQ*DATA_W-1:0]   i_req_data_b,
   output logic [N_REQ-1:0]          o_rsp_valid,
   output logic                      o_rsp_last,
   output logic [DATA_W-1:0]         o_rsp_data,
   output logic                      o_err,
   output logic [$clog2(N_REQ)-1:0]  o_grant,
   output logic                      o_alu_in_valid,
   output logic [INST_W-1:0]         o_alu_inst,
   output logic [DATA_W-1:0]         o_alu_data_a,
   output logic [DATA_W-1:0]         o_alu_data_b,
   input  logic                      i_alu_busy,
   input  logic                      i_alu_out_valid,
   input  logic [DATA_W-1:0]         i_alu_data
);

   localparam int unsigned c_GNT_W  = $clog2(N_REQ);
   localparam int unsigned c_BEAT_W = $clog2(MAT_BEATS);
   localparam int unsigned c_WD_W   = $clog2(TIMEOUT + 1);

   state_t              r_state;
   logic [c_GNT_W-1:0]  r_grant;
   logic [c_GNT_W-1:0]  r_ptr;
   logic                r_is_mat;
   logic [c_BEAT_W-1:0] r_beat_cnt;
   logic [c_BEAT_W-1:0] r_rsp_cnt;
   logic [c_WD_W-1:0]   r_wdog;
   logic [N_REQ-1:0]    r_rsp_valid;
   logic                r_rsp_last;
   logic [DATA_W-1:0]   r_rsp_data;
   logic                r_err;

   logic [c_GNT_W-1:0]  w_pick_idx;
   logic                w_pick_found;
   logic [N_REQ-1:0]    w_own_hot;
   logic                w_issue;
   logic                w_in_valid;
   logic [INST_W-1:0]   w_beat_inst;
   logic                w_mat_beat;
   logic                w_last_beat;
   logic                w_last_rsp;
   logic [c_GNT_W-1:0]  w_ptr_next;

   alu_rr_picker #(
      .N_REQ (N_REQ),
      .IDX_W (c_GNT_W)
   ) u_picker (
      .i_valid (i_req_valid),
      .i_ptr   (r_ptr),
      .o_idx   (w_pick_idx),
      .o_found (w_pick_found)
   );

   // One-hot decode of the owner, used for ready and result steering.
   for (genvar r = 0; r < N_REQ; r++) begin : g_owner_hot
      assign w_own_hot[r] = (r_grant == c_GNT_W'(r));
   end

   assign w_issue     = (r_state == ST_ISSUE);
   assign w_beat_inst = i_req_inst[r_grant*INST_W +: INST_W];
   assign w_in_valid  = w_issue & i_req_valid[r_grant] & ~i_alu_busy;

   // The first beat decides the transaction type; later beats follow the
   // latched type even if their opcode differs.
   assign w_mat_beat  = (r_beat_cnt == '0) ? (w_beat_inst == MAT_INST) : r_is_mat;
   assign w_last_beat = (r_beat_cnt == c_BEAT_W'(MAT_BEATS - 1));
   assign w_last_rsp  = r_is_mat ? (r_rsp_cnt == c_BEAT_W'(MAT_BEATS - 1)) : 1'b1;
   assign w_ptr_next  = (r_grant == c_GNT_W'(N_REQ - 1)) ? '0 : r_grant + 1'b1;

   // ALU side is a pure mux from the owner, forced to zero outside ISSUE.
   assign o_alu_in_valid = w_in_valid;
   assign o_alu_inst     = w_issue ? w_beat_inst : '0;
   assign o_alu_data_a   = w_issue ? i_req_data_a[r_grant*DATA_W +: DATA_W] : '0;
   assign o_alu_data_b   = w_issue ? i_req_data_b[r_grant*DATA_W +: DATA_W] : '0;
   assign o_req_ready    = w_in_valid ? w_own_hot : '0;

   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_last  = r_rsp_last;
   assign o_rsp_data  = r_rsp_data;
   assign o_err       = r_err;
   assign o_grant     = r_grant;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_grant     <= '0;
         r_ptr       <= '0;
         r_is_mat    <= 1'b0;
         r_beat_cnt  <= '0;
         r_rsp_cnt   <= '0;
         r_wdog      <= '0;
         r_rsp_valid <= '0;
         r_rsp_last  <= 1'b0;
         r_rsp_data  <= '0;
         r_err       <= 1'b0;
      end else begin
         r_rsp_valid <= '0;
         r_rsp_last  <= 1'b0;
         r_err       <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_pick_found) begin
                  r_grant    <= w_pick_idx;
                  r_is_mat   <= 1'b0;
                  r_beat_cnt <= '0;
                  r_rsp_cnt  <= '0;
                  r_wdog     <= '0;
                  r_state    <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               // Results seen here are spurious and deliberately dropped.
               if (w_in_valid) begin
                  if (r_beat_cnt == '0) begin
                     r_is_mat <= w_mat_beat;
                  end
                  if (!w_mat_beat || w_last_beat) begin
                     r_beat_cnt <= '0;
                     r_state    <= ST_WAIT;
                  end else begin
                     r_beat_cnt <= r_beat_cnt + 1'b1;
                  end
               end
            end
            ST_WAIT: begin
               if (i_alu_out_valid) begin
                  r_rsp_valid <= w_own_hot;
                  r_rsp_data  <= i_alu_data;
                  r_rsp_last  <= w_last_rsp;
                  r_wdog      <= '0;
                  if (w_last_rsp) begin
                     r_state <= ST_DRAIN;
                  end else begin
                     r_rsp_cnt <= r_rsp_cnt + 1'b1;
                  end
               end else if (r_wdog == c_WD_W'(TIMEOUT - 1)) begin
                  // Remaining results are abandoned; DRAIN swallows a late one.
                  r_err   <= 1'b1;
                  r_state <= ST_DRAIN;
               end else begin
                  r_wdog <= r_wdog + 1'b1;
               end
            end
            ST_DRAIN: begin
               r_ptr   <= w_ptr_next;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule : alu_arbiter
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Directed self-checking bench for alu_arbiter (N_REQ = 2) with a
//            small behavioural ALU: non-matrix ops return a+b one cycle after
//            issue, matrix ops return eight a+b results after the 8th beat.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [7:0]  req_inst;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [1:0]  rsp_valid;
   logic        rsp_last;
   logic [15:0] rsp_data;
   logic        err;
   logic [0:0]  grant;
   logic        alu_in_valid;
   logic [3:0]  alu_inst;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic        alu_busy;
   logic        alu_ov;
   logic [15:0] alu_d;
   logic        mute;

   int n_cmp;
   int n_mis;
   int rdy0, rdy1, rsp0, rsp1, err_cnt;

   alu_arbiter #(
      .N_REQ(2), .INST_W(4), .DATA_W(16), .MAT_BEATS(8),
      .MAT_INST(4'b1001), .TIMEOUT(64)
   ) dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_req_valid     (req_valid),
      .o_req_ready     (req_ready),
      .i_req_inst      (req_inst),
      .i_req_data_a    (req_a),
      .i_req_data_b    (req_b),
      .o_rsp_valid     (rsp_valid),
      .o_rsp_last      (rsp_last),
      .o_rsp_data      (rsp_data),
      .o_err           (err),
      .o_grant         (grant),
      .o_alu_in_valid  (alu_in_valid),
      .o_alu_inst      (alu_inst),
      .o_alu_data_a    (alu_a),
      .o_alu_data_b    (alu_b),
      .i_alu_busy      (alu_busy),
      .i_alu_out_valid (alu_ov),
      .i_alu_data      (alu_d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU, reset by the same reset as the arbiter.
   logic [15:0] pend[$];
   logic [15:0] outq[$];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_ov <= 1'b0;
         alu_d  <= '0;
         pend.delete();
         outq.delete();
      end else begin
         if (outq.size() > 0) begin
            alu_ov <= 1'b1;
            alu_d  <= outq.pop_front();
         end else begin
            alu_ov <= 1'b0;
         end
         if (alu_in_valid && !mute) begin
            if (alu_inst == 4'b1001) begin
               pend.push_back(16'(alu_a + alu_b));
               if (pend.size() == 8) begin
                  foreach (pend[i]) outq.push_back(pend[i]);
                  pend.delete();
               end
            end else begin
               outq.push_back(16'(alu_a + alu_b));
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge and tally the sampled outputs.
   task automatic step();
      @(negedge clk);
      rdy0    += int'(req_ready[0]);
      rdy1    += int'(req_ready[1]);
      rsp0    += int'(rsp_valid[0]);
      rsp1    += int'(rsp_valid[1]);
      err_cnt += int'(err);
   endtask

   task automatic set_req(input int r, input logic [3:0] inst,
                          input logic [15:0] a, input logic [15:0] b);
      req_inst[r*4 +: 4]   = inst;
      req_a[r*16 +: 16]    = a;
      req_b[r*16 +: 16]    = b;
      req_valid[r]         = 1'b1;
   endtask

   // Wait for the beat of requester r, hand it over, then check its result.
   task automatic serve(input int r, input logic [15:0] exp);
      int n;
      logic [1:0] hot;
      hot = 2'b01 << r;
      #1;
      n = 0;
      while (req_ready == 2'b00 && n < 20) begin step(); n++; end
      chk("serve_ready", 32'(req_ready), 32'(hot));
      chk("serve_grant", 32'(grant), 32'(r));
      step();
      req_valid[r] = 1'b0;
      n = 0;
      while (rsp_valid == 2'b00 && n < 20) begin step(); n++; end
      chk("serve_rsp_valid", 32'(rsp_valid), 32'(hot));
      chk("serve_rsp_last", 32'(rsp_last), 32'd1);
      chk("serve_rsp_data", 32'(rsp_data), 32'(exp));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "global timeout");
   end

   initial begin
      int n, got, base0, base1, first;
      n_cmp = 0; n_mis = 0;
      rdy0 = 0; rdy1 = 0; rsp0 = 0; rsp1 = 0; err_cnt = 0;
      rst_n = 1'b0; req_valid = '0; req_inst = '0; req_a = '0; req_b = '0;
      alu_busy = 1'b0; mute = 1'b0;

      // ---- reset state
      step(); step();
      chk("rst_ctrl", 32'({req_ready, rsp_valid, rsp_last, err, grant, alu_in_valid}), 32'd0);
      chk("rst_alu", 32'({alu_inst, alu_a, alu_b}), 32'd0);
      chk("rst_rsp_data", 32'(rsp_data), 32'd0);
      rst_n = 1'b1;

      // ---- single ADD: 1.0 + 2.0 = 3.0
      step();
      base0 = rdy0;
      set_req(0, 4'b0000, 16'h0400, 16'h0800);
      step();
      chk("add_ready", 32'(req_ready), 32'h1);
      chk("add_alu_valid", 32'(alu_in_valid), 32'h1);
      chk("add_alu_ops", 32'({alu_a, alu_b}), 32'h0400_0800);
      step();
      chk("add_ready_drop", 32'(req_ready), 32'h0);
      req_valid[0] = 1'b0;
      n = 0;
      while (rsp_valid == 2'b00 && n < 20) begin step(); n++; end
      chk("add_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("add_rsp_last", 32'(rsp_last), 32'h1);
      chk("add_rsp_data", 32'(rsp_data), 32'h0C00);
      chk("add_ready_cycles", 32'(rdy0 - base0), 32'd1);
      step();
      chk("add_rsp_clear", 32'(rsp_valid), 32'h0);
      // IDLE now: a fresh request must be granted on the very next edge.
      set_req(1, 4'b0000, 16'h0100, 16'h0100);
      step();
      chk("add_back_idle", 32'(req_ready), 32'h2);
      serve(1, 16'h0200);

      // ---- contention from reset: order 0,1,0,1
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      set_req(0, 4'b0000, 16'h0100, 16'h0100);
      set_req(1, 4'b0000, 16'h0200, 16'h0300);
      serve(0, 16'h0200);
      set_req(0, 4'b0000, 16'h0000, 16'h0400);
      serve(1, 16'h0500);
      set_req(1, 4'b0000, 16'h0400, 16'h0400);
      serve(0, 16'h0400);
      serve(1, 16'h0800);

      // ---- matrix burst from req1 with gaps while req0 waits
      step();
      set_req(1, 4'b1001, 16'h0000, 16'h0010);
      #1;
      n = 0;
      while (req_ready == 2'b00 && n < 20) begin step(); n++; end
      set_req(0, 4'b0000, 16'h0800, 16'h0800);
      base0 = rdy0;
      base1 = rsp1;
      for (int k = 0; k < 8; k++) begin
         set_req(1, 4'b1001, 16'(k * 16'h0100), 16'h0010);
         #1;
         chk("mat_beat_ready", 32'(req_ready), 32'h2);
         step();
         req_valid[1] = 1'b0;
         #1;
         if (k < 7) begin
            chk("mat_gap_in_valid", 32'(alu_in_valid), 32'h0);
            step();
         end
      end
      got = 0;
      for (int s = 0; s < 40 && got < 8; s++) begin
         step();
         if (rsp_valid != 2'b00) begin
            chk("mat_rsp_valid", 32'(rsp_valid), 32'h2);
            chk("mat_rsp_data", 32'(rsp_data), 32'(got * 32'h0100 + 32'h0010));
            chk("mat_rsp_last", 32'(rsp_last), 32'(got == 7));
            got++;
         end
      end
      chk("mat_rsp_count", 32'(got), 32'd8);
      chk("mat_rsp1_total", 32'(rsp1 - base1), 32'd8);
      chk("mat_req0_no_ready", 32'(rdy0 - base0), 32'd0);
      serve(0, 16'h1000);

      // ---- busy backpressure for 5 ISSUE cycles: 3.0 + (-1.0) = 2.0
      step();
      alu_busy = 1'b1;
      set_req(0, 4'b0000, 16'h0C00, 16'hFC00);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("busy_hold", 32'({alu_in_valid, req_ready}), 32'h0);
      end
      alu_busy = 1'b0;
      #1;
      chk("busy_release_ready", 32'(req_ready), 32'h1);
      serve(0, 16'h0800);

      // ---- watchdog: ALU swallows the beat and never answers
      step();
      mute = 1'b1;
      set_req(1, 4'b0000, 16'h0100, 16'h0100);
      #1;
      n = 0;
      while (req_ready == 2'b00 && n < 20) begin step(); n++; end
      chk("wd_ready", 32'(req_ready), 32'h2);
      step();
      req_valid[1] = 1'b0;
      set_req(0, 4'b0000, 16'h0200, 16'h0200);
      base1 = rsp1;
      n = err_cnt;
      first = -1;
      for (int i = 1; i <= 100 && first < 0; i++) begin
         step();
         if (err) first = i;
      end
      mute = 1'b0;
      chk("wd_err_delay", 32'(first), 32'd64);
      step();
      chk("wd_err_pulse", 32'(err), 32'd0);
      chk("wd_err_once", 32'(err_cnt - n), 32'd1);
      chk("wd_no_rsp", 32'(rsp1 - base1), 32'd0);
      serve(0, 16'h0400);

      // ---- async reset after 4 matrix beats
      step();
      set_req(0, 4'b1001, 16'h0000, 16'h0001);
      #1;
      n = 0;
      while (req_ready == 2'b00 && n < 20) begin step(); n++; end
      for (int k = 0; k < 4; k++) begin
         set_req(0, 4'b1001, 16'(k), 16'h0001);
         step();
      end
      set_req(0, 4'b1001, 16'h0004, 16'h0001);
      #1;
      chk("mid_mat_ready", 32'(req_ready), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_ctrl", 32'({req_ready, rsp_valid, rsp_last, err, grant, alu_in_valid}), 32'd0);
      chk("arst_alu", 32'({alu_inst, alu_a, alu_b}), 32'd0);
      chk("arst_rsp_data", 32'(rsp_data), 32'd0);
      req_valid = '0;
      step(); step();
      rst_n = 1'b1;
      step();
      // Pointer back at 0: req0 wins a tie, then req1's ADD completes.
      set_req(0, 4'b0000, 16'h1000, 16'h0400);
      set_req(1, 4'b0000, 16'h0001, 16'h0002);
      serve(0, 16'h1400);
      serve(1, 16'h0003);

      step(); step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule : tb_alu_arbiter
`default_nettype wire
